// File: rtl/sdram_word_controller.sv
// rtl/sdram_word_controller.sv - single-word SDRAM controller (CL2, BL1, auto-precharge, periodic refresh)
// Optional read/write statistics on debugString when SDRAM_STATS_EN is defined.
module sdram_word_controller #(
    parameter int INIT_WAIT      = 10000,
    parameter int REFRESH_PERIOD = 375,
    parameter int T_RFC          = 4
) (
    input  logic        clock_50Mhz,
    input  logic        reset_n,
    input  logic [24:0] sdram_inputAddress,
    input  logic [15:0] sdram_writeData,
    input  logic        sdram_isWriting,
    input  logic        sdram_inputValid,
    output logic        sdram_recievedCommand,
    output logic        sdram_isBusy,
    output logic [15:0] sdram_readData,
    output logic        sdram_outputValid,
    output logic [3:0]  dram_cmd_n,
    output logic [12:0] dram_addr,
    output logic [1:0]  dram_ba,
    output logic        dram_cke,
    output logic [1:0]  dram_dqm,
    output logic [15:0] dram_dq_out,
    output logic        dram_dq_oe,
    input  logic [15:0] dram_dq_in,
    output logic [31:0] debugString
);
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_PRECHARGE, S_TRP, S_REF1, S_RFC1, S_REF2, S_RFC2, S_LMR,
        S_LMR_WAIT, S_IDLE, S_ACTIVE, S_RW, S_WAIT1, S_WAIT2, S_REFRESH, S_REF_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] ref_cnt_q, ref_cnt_d;
    logic        ref_started_q, ref_started_d;
    logic        ref_pending_q, ref_pending_d;
    logic        cke_q;
    logic [24:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ovalid_q, ovalid_d;
    logic        accept;
    logic        ref_expire;
    logic        refresh_req;

    assign ref_expire  = ref_started_q && (ref_cnt_q == 16'd1);
    assign refresh_req = ref_pending_q | ref_expire;

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_INIT_WAIT;
            cnt_q         <= '0;
            ref_cnt_q     <= '0;
            ref_started_q <= 1'b0;
            ref_pending_q <= 1'b0;
            cke_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            rdata_q       <= '0;
            ovalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_started_q <= ref_started_d;
            ref_pending_q <= ref_pending_d;
            cke_q         <= 1'b1;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wr_q          <= wr_d;
            rdata_q       <= rdata_d;
            ovalid_q      <= ovalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_INIT_WAIT: if (cke_q && cnt_q == 16'(INIT_WAIT - 1)) state_d = S_PRECHARGE;
            S_PRECHARGE: state_d = S_TRP;
            S_TRP:       state_d = S_REF1;
            S_REF1:      state_d = S_RFC1;
            S_RFC1:      if (cnt_q == 16'(T_RFC - 1)) state_d = S_REF2;
            S_REF2:      state_d = S_RFC2;
            S_RFC2:      if (cnt_q == 16'(T_RFC - 1)) state_d = S_LMR;
            S_LMR:       state_d = S_LMR_WAIT;
            S_LMR_WAIT:  if (cnt_q == 16'd1) state_d = S_IDLE;
            S_IDLE: begin
                // Refresh wins over a coincident request; the request simply waits.
                if (refresh_req) begin
                    state_d = S_REFRESH;
                end else if (sdram_inputValid) begin
                    accept  = 1'b1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE:    state_d = S_RW;
            S_RW:        state_d = S_WAIT1;
            S_WAIT1:     state_d = S_WAIT2;
            S_WAIT2:     state_d = S_IDLE;
            S_REFRESH:   state_d = S_REF_WAIT;
            S_REF_WAIT:  if (cnt_q == 16'(T_RFC - 1)) state_d = S_IDLE;
            default:     state_d = S_INIT_WAIT;
        endcase

        // Per-state cycle counter; the power-up wait only starts once CKE is high.
        if (state_d != state_q || (state_q == S_INIT_WAIT && !cke_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        ref_cnt_d     = ref_cnt_q;
        ref_started_d = ref_started_q;
        ref_pending_d = ref_pending_q;
        if (!ref_started_q) begin
            if (state_d == S_IDLE) begin
                ref_cnt_d     = 16'(REFRESH_PERIOD);
                ref_started_d = 1'b1;
            end
        end else if (ref_expire) begin
            ref_cnt_d = 16'(REFRESH_PERIOD);
        end else begin
            ref_cnt_d = ref_cnt_q - 16'd1;
        end
        if (state_q == S_REFRESH) ref_pending_d = 1'b0;
        if (ref_expire)           ref_pending_d = 1'b1;
    end

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        ovalid_d = 1'b0;
        if (accept) begin
            addr_d  = sdram_inputAddress;
            wdata_d = sdram_writeData;
            wr_d    = sdram_isWriting;
        end
        // CL2 after the READ at A+2 puts data on the bus during A+4.
        if (state_q == S_WAIT2 && !wr_q) begin
            rdata_d  = dram_dq_in;
            ovalid_d = 1'b1;
        end
    end

    always_comb begin
        dram_cmd_n  = CMD_NOP;
        dram_addr   = '0;
        dram_ba     = '0;
        dram_dq_out = '0;
        dram_dq_oe  = 1'b0;
        case (state_q)
            S_PRECHARGE: begin
                dram_cmd_n = CMD_PRECHARGE;
                dram_addr  = 13'h0400;
            end
            S_REF1, S_REF2, S_REFRESH: dram_cmd_n = CMD_REFRESH;
            S_LMR: begin
                dram_cmd_n = CMD_LOAD_MODE;
                dram_addr  = 13'h0020;
            end
            S_ACTIVE: begin
                dram_cmd_n = CMD_ACTIVE;
                dram_ba    = addr_q[24:23];
                dram_addr  = addr_q[22:10];
            end
            S_RW: begin
                dram_ba   = addr_q[24:23];
                dram_addr = {2'b00, 1'b1, addr_q[9:0]};
                if (wr_q) begin
                    dram_cmd_n  = CMD_WRITE;
                    dram_dq_oe  = 1'b1;
                    dram_dq_out = wdata_q;
                end else begin
                    dram_cmd_n = CMD_READ;
                end
            end
            default: ;
        endcase
    end

    assign sdram_recievedCommand = accept;
    assign sdram_isBusy          = (state_q != S_IDLE) | refresh_req;
    assign sdram_readData        = rdata_q;
    assign sdram_outputValid     = ovalid_q;
    assign dram_cke              = cke_q;
    assign dram_dqm              = 2'b00;

`ifdef SDRAM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (accept) begin
            if (sdram_isWriting) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign debugString = {rd_cnt_q, wr_cnt_q};
`else
    assign debugString = 32'h0;
`endif

endmodule

// File: tb/tb_sdram_word_controller.sv
// tb/tb_sdram_word_controller.sv - directed self-checking bench for sdram_word_controller
module tb_sdram_word_controller;
    localparam int INIT_W = 20;
    localparam int REF_P  = 200;
    localparam int TRFC   = 4;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [24:0] sdram_inputAddress;
    logic [15:0] sdram_writeData;
    logic        sdram_isWriting;
    logic        sdram_inputValid;
    logic        sdram_recievedCommand;
    logic        sdram_isBusy;
    logic [15:0] sdram_readData;
    logic        sdram_outputValid;
    logic [3:0]  dram_cmd_n;
    logic [12:0] dram_addr;
    logic [1:0]  dram_ba;
    logic        dram_cke;
    logic [1:0]  dram_dqm;
    logic [15:0] dram_dq_out;
    logic        dram_dq_oe;
    logic [15:0] dram_dq_in = 16'h0;
    logic [31:0] debugString;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int idle_cyc;
    int acc_cyc;

    logic [15:0] mem   = 16'h0;
    logic [1:0]  rd_sh = 2'b00;
    logic [3:0]  init_seq [0:13] = '{C_NOP, C_REF, C_NOP, C_NOP, C_NOP, C_NOP, C_REF,
                                     C_NOP, C_NOP, C_NOP, C_NOP, C_LMR, C_NOP, C_NOP};

    sdram_word_controller #(.INIT_WAIT(INIT_W), .REFRESH_PERIOD(REF_P), .T_RFC(TRFC)) dut (
        .clock_50Mhz          (clk),
        .reset_n              (reset_n),
        .sdram_inputAddress   (sdram_inputAddress),
        .sdram_writeData      (sdram_writeData),
        .sdram_isWriting      (sdram_isWriting),
        .sdram_inputValid     (sdram_inputValid),
        .sdram_recievedCommand(sdram_recievedCommand),
        .sdram_isBusy         (sdram_isBusy),
        .sdram_readData       (sdram_readData),
        .sdram_outputValid    (sdram_outputValid),
        .dram_cmd_n           (dram_cmd_n),
        .dram_addr            (dram_addr),
        .dram_ba              (dram_ba),
        .dram_cke             (dram_cke),
        .dram_dqm             (dram_dqm),
        .dram_dq_out          (dram_dq_out),
        .dram_dq_oe           (dram_dq_oe),
        .dram_dq_in           (dram_dq_in),
        .debugString          (debugString)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-word SDRAM model: remembers the last written word, returns it two cycles after READ.
    always @(posedge clk) begin
        if (dram_cmd_n == C_WR && dram_dq_oe) mem <= dram_dq_out;
        rd_sh      <= {rd_sh[0], dram_cmd_n == C_RD};
        dram_dq_in <= rd_sh[0] ? mem : 16'h0;
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [24:0] a, input logic [15:0] d);
        int n = 0;
        while (sdram_isBusy && n < 600) begin
            next_cycle();
            n++;
        end
        if (sdram_isBusy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout busy=%b required 0", sdram_isBusy);
        end
        sdram_isWriting    = wr;
        sdram_inputAddress = a;
        sdram_writeData    = d;
        sdram_inputValid   = 1'b1;
        #1;
        acc_cyc = cyc;
    endtask

    task automatic test_init();
        int n;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n = 0;
        while (!dram_cke && n < 4) begin
            next_cycle();
            n++;
        end
        checks++;
        if (dram_cke !== 1'b1) begin errors++; $display("FAIL init_cke got=%b want=1", dram_cke); end
        n = 0;
        while (dram_cmd_n == C_NOP && n < INIT_W + 10) begin
            next_cycle();
            n++;
        end
        checks++;
        if (n !== INIT_W) begin errors++; $display("FAIL init_wait_len got=%0d want=%0d", n, INIT_W); end
        checks++;
        if (dram_cmd_n !== C_PRE || dram_addr !== 13'h0400) begin
            errors++;
            $display("FAIL init_precharge cmd=%b addr=%h want cmd=%b addr=0400", dram_cmd_n, dram_addr, C_PRE);
        end
        for (int i = 0; i < 14; i++) begin
            next_cycle();
            checks++;
            if (dram_cmd_n !== init_seq[i] || sdram_isBusy !== 1'b1) begin
                errors++;
                $display("FAIL init_seq[%0d] cmd=%b busy=%b want cmd=%b busy=1", i, dram_cmd_n, sdram_isBusy, init_seq[i]);
            end
            if (init_seq[i] == C_LMR) begin
                checks++;
                if (dram_addr !== 13'h0020) begin errors++; $display("FAIL init_lmr_addr got=%h want=0020", dram_addr); end
            end
        end
        next_cycle();
        checks++;
        if (sdram_isBusy !== 1'b0) begin errors++; $display("FAIL init_idle_busy got=%b want=0", sdram_isBusy); end
        idle_cyc = cyc;
    endtask

    task automatic test_reset();
        checks++;
        if (dram_cmd_n !== C_NOP || dram_cke !== 1'b0 || dram_dq_oe !== 1'b0 || dram_dqm !== 2'b00) begin
            errors++;
            $display("FAIL reset_dram cmd=%b cke=%b oe=%b dqm=%b want 0111/0/0/00", dram_cmd_n, dram_cke, dram_dq_oe, dram_dqm);
        end
        checks++;
        if (sdram_recievedCommand !== 1'b0 || sdram_outputValid !== 1'b0 || sdram_readData !== 16'h0 ||
            dram_addr !== 13'h0 || dram_ba !== 2'b00 || dram_dq_out !== 16'h0 || debugString !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs recv=%b ov=%b rd=%h addr=%h ba=%b dq=%h dbg=%h want all 0",
                     sdram_recievedCommand, sdram_outputValid, sdram_readData, dram_addr, dram_ba, dram_dq_out, debugString);
        end
        test_init();
    endtask

    task automatic test_write();
        issue(1'b1, 25'h1ABCDEF, 16'hBEEF);
        checks++;
        if (sdram_recievedCommand !== 1'b1) begin errors++; $display("FAIL wr_accept got=%b want=1", sdram_recievedCommand); end
        next_cycle();
        sdram_inputValid = 1'b0;
        checks++;
        if (dram_cmd_n !== C_ACT || dram_ba !== 2'd3 || dram_addr !== 13'h0AF3 || sdram_recievedCommand !== 1'b0) begin
            errors++;
            $display("FAIL wr_active cmd=%b ba=%0d addr=%h recv=%b want 0011/3/0af3/0", dram_cmd_n, dram_ba, dram_addr, sdram_recievedCommand);
        end
        next_cycle();
        checks++;
        if (dram_cmd_n !== C_WR || dram_ba !== 2'd3 || dram_addr !== 13'h05EF || dram_dq_oe !== 1'b1 || dram_dq_out !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_write cmd=%b ba=%0d addr=%h oe=%b dq=%h want 0100/3/05ef/1/beef", dram_cmd_n, dram_ba, dram_addr, dram_dq_oe, dram_dq_out);
        end
        next_cycle();
        checks++;
        if (dram_dq_oe !== 1'b0 || dram_cmd_n !== C_NOP) begin
            errors++;
            $display("FAIL wr_oe_drop oe=%b cmd=%b want 0/0111", dram_dq_oe, dram_cmd_n);
        end
        next_cycle();
        checks++;
        if (sdram_isBusy !== 1'b1) begin errors++; $display("FAIL wr_busy_a4 got=%b want=1", sdram_isBusy); end
        next_cycle();
        checks++;
        if (sdram_isBusy !== 1'b0 || cyc !== acc_cyc + 5) begin
            errors++;
            $display("FAIL wr_idle_a5 busy=%b at=%0d want busy=0 at=%0d", sdram_isBusy, cyc, acc_cyc + 5);
        end
    endtask

    task automatic test_read();
        issue(1'b0, 25'h1ABCDEF, 16'h0000);
        checks++;
        if (sdram_recievedCommand !== 1'b1) begin errors++; $display("FAIL rd_accept got=%b want=1", sdram_recievedCommand); end
        next_cycle();
        sdram_inputValid = 1'b0;
        next_cycle();
        checks++;
        if (dram_cmd_n !== C_RD || dram_addr !== 13'h05EF || dram_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL rd_read cmd=%b addr=%h oe=%b want 0101/05ef/0", dram_cmd_n, dram_addr, dram_dq_oe);
        end
        for (int k = 3; k <= 4; k++) begin
            next_cycle();
            checks++;
            if (sdram_outputValid !== 1'b0) begin errors++; $display("FAIL rd_early_valid a+%0d got=%b want=0", k, sdram_outputValid); end
        end
        next_cycle();
        checks++;
        if (sdram_outputValid !== 1'b1 || sdram_readData !== 16'hBEEF || cyc !== acc_cyc + 5) begin
            errors++;
            $display("FAIL rd_valid ov=%b data=%h at=%0d want 1/beef at=%0d", sdram_outputValid, sdram_readData, cyc, acc_cyc + 5);
        end
        next_cycle();
        checks++;
        if (sdram_outputValid !== 1'b0 || sdram_readData !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_hold ov=%b data=%h want 0/beef", sdram_outputValid, sdram_readData);
        end
    endtask

    task automatic test_refresh_priority();
        int x;
        int n;
        x = idle_cyc + REF_P - 1;
        while (x <= cyc + 1) x += REF_P;
        while (cyc < x - 1) next_cycle();
        @(negedge clk);
        sdram_isWriting    = 1'b0;
        sdram_inputAddress = 25'h1ABCDEF;
        sdram_inputValid   = 1'b1;
        #1;
        checks++;
        if (sdram_recievedCommand !== 1'b0 || sdram_isBusy !== 1'b1) begin
            errors++;
            $display("FAIL ref_expiry_cycle recv=%b busy=%b want 0/1", sdram_recievedCommand, sdram_isBusy);
        end
        next_cycle();
        checks++;
        if (dram_cmd_n !== C_REF || sdram_recievedCommand !== 1'b0) begin
            errors++;
            $display("FAIL ref_first cmd=%b recv=%b want 0001/0", dram_cmd_n, sdram_recievedCommand);
        end
        n = 0;
        while (!sdram_recievedCommand && n < 20) begin
            next_cycle();
            n++;
        end
        checks++;
        if (sdram_recievedCommand !== 1'b1 || cyc !== x + 2 + TRFC) begin
            errors++;
            $display("FAIL ref_late_accept recv=%b at=%0d want 1 at=%0d", sdram_recievedCommand, cyc, x + 2 + TRFC);
        end
        next_cycle();
        sdram_inputValid = 1'b0;
        repeat (6) next_cycle();
    endtask

    task automatic test_reset_mid_read();
        issue(1'b0, 25'h0012345, 16'h0000);
        checks++;
        if (sdram_recievedCommand !== 1'b1) begin errors++; $display("FAIL mid_accept got=%b want=1", sdram_recievedCommand); end
        next_cycle();
        sdram_inputValid = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b0;
        #1;
        checks++;
        if (dram_cmd_n !== C_NOP || dram_cke !== 1'b0 || dram_dq_oe !== 1'b0 || sdram_outputValid !== 1'b0 ||
            sdram_readData !== 16'h0 || dram_addr !== 13'h0 || dram_ba !== 2'b00 || debugString !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs cmd=%b cke=%b oe=%b ov=%b rd=%h addr=%h ba=%b dbg=%h want 0111/0/0/0/0/0/0/0",
                     dram_cmd_n, dram_cke, dram_dq_oe, sdram_outputValid, sdram_readData, dram_addr, dram_ba, debugString);
        end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            checks++;
            if (sdram_outputValid !== 1'b0 || dram_cmd_n !== C_NOP) begin
                errors++;
                $display("FAIL mid_reset_hold[%0d] ov=%b cmd=%b want 0/0111", k, sdram_outputValid, dram_cmd_n);
            end
        end
        test_init();
    endtask

    task automatic test_stats();
        logic        wr_pat [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] want;
        for (int i = 0; i < 5; i++) begin
            issue(wr_pat[i], 25'h0000100 + 25'(i), 16'h1000 + 16'(i));
            checks++;
            if (sdram_recievedCommand !== 1'b1) begin errors++; $display("FAIL stats_accept[%0d] got=%b want=1", i, sdram_recievedCommand); end
            next_cycle();
            sdram_inputValid = 1'b0;
            repeat (5) next_cycle();
        end
`ifdef SDRAM_STATS_EN
        want = 32'h0002_0003;
`else
        want = 32'h0000_0000;
`endif
        checks++;
        if (debugString !== want) begin errors++; $display("FAIL stats_debug got=%h want=%h", debugString, want); end
    endtask

    initial begin
        reset_n            = 1'b0;
        sdram_inputAddress = '0;
        sdram_writeData    = '0;
        sdram_isWriting    = 1'b0;
        sdram_inputValid   = 1'b0;
        repeat (3) next_cycle();
        test_reset();
        test_write();
        test_read();
        test_refresh_priority();
        test_reset_mid_read();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
